// File: rtl/imm_ext_pipe_if.sv
// Interface bundling the decode-side handshake and result bus of imm_ext_pipe.
// master: decode stage driving raw immediates and consuming results.
// slave:  the immediate-extension unit.
interface imm_ext_pipe_if #(
    parameter int unsigned IMM_W  = 9,
    parameter int unsigned DATA_W = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  immed;
    logic [1:0]        mode;
    logic              pfx_load;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext_immed;
    logic              pfx_pending;

    modport master (
        output flush,
        output in_valid,
        output immed,
        output mode,
        output pfx_load,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ext_immed,
        input  pfx_pending
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  immed,
        input  mode,
        input  pfx_load,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ext_immed,
        output pfx_pending
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit for the fdt16 decode stage.
// Extends a raw IMM_W-bit immediate to DATA_W bits in one of four modes, optionally
// combining it with a previously loaded prefix, and holds the result in a one-entry
// registered output with valid/ready handshake.
// Optional feature macro: IMM_EXT_PFX_EN (prefix register and pfx_load support).
// With the macro undefined, pfx_load is ignored and pfx_pending is tied low.
module imm_ext_pipe #(
    parameter int unsigned IMM_W  = 9,
    parameter int unsigned DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    imm_ext_pipe_if.slave if_bus
);
    // Prefix payload fills exactly the bits above the raw immediate.
    localparam int unsigned PFX_W = DATA_W - IMM_W;

    generate
        if (DATA_W < IMM_W + 1) begin : g_bad_params
            $error("imm_ext_pipe: DATA_W must be at least IMM_W+1");
        end
    endgenerate

    localparam logic [1:0] ModeSign   = 2'b00;
    localparam logic [1:0] ModeZero   = 2'b01;
    localparam logic [1:0] ModeUpper  = 2'b10;
    localparam logic [1:0] ModeBranch = 2'b11;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_ext_immed;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_pop;
    logic              w_data_accept;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_mode_result;
    logic [DATA_W-1:0] w_result;

    // A held result blocks input unless it is being consumed this cycle.
    assign w_in_ready = !if_bus.flush && (!r_out_valid || if_bus.out_ready);
    assign w_accept   = if_bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && if_bus.out_ready;

    assign w_sext = {{PFX_W{if_bus.immed[IMM_W-1]}}, if_bus.immed};
    assign w_zext = {{PFX_W{1'b0}}, if_bus.immed};

    // Plain mode decode of the raw immediate.
    always_comb begin
        w_mode_result = w_sext;
        unique case (if_bus.mode)
            ModeSign:   w_mode_result = w_sext;
            ModeZero:   w_mode_result = w_zext;
            ModeUpper:  w_mode_result = w_zext << PFX_W;
            ModeBranch: w_mode_result = w_sext << 1;
            default:    w_mode_result = w_sext;
        endcase
    end

`ifdef IMM_EXT_PFX_EN
    logic [PFX_W-1:0] r_pfx;
    logic             r_pfx_pending;

    // Prefix register: loaded by a prefix transaction, cleared by any data transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pfx         <= '0;
            r_pfx_pending <= 1'b0;
        end else if (if_bus.flush) begin
            r_pfx_pending <= 1'b0;
        end else if (w_accept && if_bus.pfx_load) begin
            r_pfx         <= if_bus.immed[PFX_W-1:0];
            r_pfx_pending <= 1'b1;
        end else if (w_accept) begin
            r_pfx_pending <= 1'b0;
        end
    end

    // A pending prefix overrides the mode decode entirely.
    assign w_result           = r_pfx_pending ? {r_pfx, if_bus.immed} : w_mode_result;
    assign w_data_accept      = w_accept && !if_bus.pfx_load;
    assign if_bus.pfx_pending = r_pfx_pending;
`else
    logic w_unused_pfx_load;

    assign w_unused_pfx_load  = if_bus.pfx_load;
    assign w_result           = w_mode_result;
    assign w_data_accept      = w_accept;
    assign if_bus.pfx_pending = 1'b0;
`endif

    // One-entry output register; ext_immed keeps its last value once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ext_immed <= '0;
        end else if (if_bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_data_accept) begin
            r_out_valid <= 1'b1;
            r_ext_immed <= w_result;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign if_bus.in_ready  = w_in_ready;
    assign if_bus.out_valid = r_out_valid;
    assign if_bus.ext_immed = r_ext_immed;
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the fdt16 decode stage. Generalises the combinational 9-to-16 sign extender.
- Adds:
  - selectable extension modes;
  - a prefix register that builds full-width immediates across two instructions;
  - a one-entry registered output with valid/ready handshake, so decode can stall without losing an immediate.

Parameters:
- IMM_W, 9, width of raw instruction immediate field.
- DATA_W, 16, datapath/output width. Must satisfy DATA_W >= IMM_W+1.
- PFX_W, DATA_W-IMM_W, prefix payload width. Derived localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush. Drops the output entry and the pending prefix.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept input this cycle.
- immed  in  IMM_W  raw immediate field.
- mode  in  2  extension mode:
  - 00 sign
  - 01 zero
  - 10 upper
  - 11 branch (sign, <<1)
- pfx_load  in  1  this transaction is a prefix (store immed, no output).
- out_valid  out  1  ext_immed holds a valid result.
- out_ready  in  1  consumer accepts result this cycle.
- ext_immed  out  DATA_W  extended immediate.
- pfx_pending  out  1  a prefix is stored and awaiting consumption.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, ext_immed=0, pfx_pending=0, prefix register=0. rst has priority over everything.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - Accept = in_valid && in_ready.
  - Output pops on out_valid && out_ready.
- Latency: result is registered. An accepted input appears on ext_immed/out_valid the next cycle.
- Full throughput: accept and pop in the same cycle are legal; the register reloads.
- Output stability: while out_valid=1 && out_ready=0, ext_immed is held stable and in_ready=0.
- Non-accepting cycles: out_valid clears on pop without a new accept. ext_immed keeps its last value when out_valid=0.
- Mode arithmetic (no prefix pending), results truncated to DATA_W:
  - 00: sign extend immed[IMM_W-1] into the upper bits.
  - 01: zero extend.
  - 10: immed << PFX_W (upper placement, low PFX_W bits zero, MSBs beyond DATA_W discarded).
  - 11: sign-extended immed << 1 (word-aligned branch offset).
- Prefix accept (pfx_load=1):
  - Prefix register <= immed[PFX_W-1:0] (upper immed bits ignored), pfx_pending <= 1.
  - No output is produced; out_valid is unaffected except by a concurrent pop.
- Prefix consumption:
  - A non-prefix accept with pfx_pending=1 produces {prefix, immed}, regardless of mode.
  - pfx_pending clears in that same cycle.
- Back-to-back prefixes: the second overwrites the first; pfx_pending stays 1.
- Flush:
  - out_valid <= 0 and pfx_pending <= 0 next edge.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - Flush overrides a concurrent pop; the data is discarded either way.
- Reset mid-operation: any stored prefix and any held result are discarded. The first post-reset non-prefix transaction uses plain mode decode.
- Illegal parameters (DATA_W < IMM_W+1) abort elaboration via generate-time check.

Optional Feature:
- Macro: IMM_EXT_PFX_EN.
- Defined: prefix register and pfx_load behaviour exist as above.
- Undefined:
  - No prefix register is synthesised; pfx_pending is tied 0.
  - pfx_load is ignored, and the transaction is processed as a normal mode-decoded transaction producing an output.

Test Plan (IMM_W=9, DATA_W=16, out_ready=1 unless stated):
- Sign mode 00, immed 0x001/0x100/0x1FF -> ext_immed 0x0001/0xFF00/0xFFFF, each one cycle after accept, out_valid=1.
- Zero mode 01, immed 0x1FF -> 0x01FF. Upper mode 10, immed 0x1FF -> 0xFF80. Branch mode 11, immed 0x100 -> 0xFE00; immed 0x003 -> 0x0006.
- Prefix (IMM_EXT_PFX_EN defined):
  - pfx_load=1 immed 0x07F -> no out_valid, pfx_pending=1.
  - Then immed 0x155 mode 01 -> ext_immed 0xFF55, pfx_pending=0.
  - Without macro: the first transaction outputs 0x007F (sign mode 00).
- Backpressure:
  - out_ready=0 after result 0xFF00 -> ext_immed holds 0xFF00 and in_ready=0 for 5 cycles.
  - Then out_ready=1 with new input 0x001 mode 00 -> 0x0001 the next cycle, no bubble.
- Flush:
  - Prefix stored, result pending, flush=1 with in_valid=1 -> next cycle out_valid=0, pfx_pending=0, input not accepted.
  - Next immed 0x155 mode 00 -> 0xFF55 via sign extension only.
- Reset mid-operation:
  - rst=1 while out_valid=1 and pfx_pending=1 -> next cycle out_valid=0, ext_immed=0, pfx_pending=0.
  - The following immed 0x0AA mode 01 -> 0x00AA.
